// File: rtl/fetch_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_decode_stage
// Purpose  : PC register, IF/ID pipeline register, ID/EX flush request and
//            saturating stall/flush event counters.
// Revision : 1.0
// ============================================================================
module fetch_decode_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
   parameter int          CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             FEN,
   input  logic             DEN,
   input  logic             PCSrcE,
   input  logic [31:0]      PCTargetE,
   input  logic [31:0]      InstrF,
   output logic [31:0]      PCF,
   output logic [31:0]      InstrD,
   output logic [31:0]      PCD,
   output logic [31:0]      PCPlus4D,
   output logic             ValidD,
   output logic             FlushE,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] FlushCount
);

   localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [31:0]      r_pc_f;
   logic [31:0]      r_instr_d;
   logic [31:0]      r_pc_d;
   logic [31:0]      r_pc_plus4_d;
   logic             r_valid_d;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   logic [31:0]      w_pc_plus4_f;
   logic [31:0]      w_pc_target_aligned;
   logic             w_stall_evt;

   assign w_pc_plus4_f        = r_pc_f + 32'd4;
   assign w_pc_target_aligned = {PCTargetE[31:2], 2'b00};
   // A redirect in the same cycle as a stall is counted only as a flush.
   assign w_stall_evt         = ~FEN & ~PCSrcE;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc_f <= RESET_PC;
      end else if (PCSrcE) begin
         r_pc_f <= w_pc_target_aligned;
      end else if (FEN) begin
         r_pc_f <= w_pc_plus4_f;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_instr_d    <= NOP_INSTR;
         r_pc_d       <= 32'd0;
         r_pc_plus4_d <= 32'd0;
         r_valid_d    <= 1'b0;
      end else if (PCSrcE) begin
         r_instr_d    <= NOP_INSTR;
         r_pc_d       <= 32'd0;
         r_pc_plus4_d <= 32'd0;
         r_valid_d    <= 1'b0;
      end else if (DEN) begin
         r_instr_d    <= InstrF;
         r_pc_d       <= r_pc_f;
         r_pc_plus4_d <= w_pc_plus4_f;
         r_valid_d    <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall_evt && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
         end
         if (PCSrcE && (r_flush_cnt != c_CNT_MAX)) begin
            r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
         end
      end
   end

   assign PCF        = r_pc_f;
   assign InstrD     = r_instr_d;
   assign PCD        = r_pc_d;
   assign PCPlus4D   = r_pc_plus4_d;
   assign ValidD     = r_valid_d;
   assign FlushE     = PCSrcE | ~DEN;
   assign StallCount = r_stall_cnt;
   assign FlushCount = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_decode_stage
// Purpose  : Directed self-checking bench for fetch_decode_stage (CNT_W=4).
// Revision : 1.0
// ============================================================================
module tb_fetch_decode_stage;

   localparam int c_CNT_W = 4;

   logic               clk;
   logic               rst;
   logic               FEN;
   logic               DEN;
   logic               PCSrcE;
   logic [31:0]        PCTargetE;
   logic [31:0]        InstrF;
   logic [31:0]        PCF;
   logic [31:0]        InstrD;
   logic [31:0]        PCD;
   logic [31:0]        PCPlus4D;
   logic               ValidD;
   logic               FlushE;
   logic [c_CNT_W-1:0] StallCount;
   logic [c_CNT_W-1:0] FlushCount;

   int checks = 0;
   int errors = 0;

   fetch_decode_stage #(
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (32'h0000_0013),
      .CNT_W     (c_CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .FEN        (FEN),
      .DEN        (DEN),
      .PCSrcE     (PCSrcE),
      .PCTargetE  (PCTargetE),
      .InstrF     (InstrF),
      .PCF        (PCF),
      .InstrD     (InstrD),
      .PCD        (PCD),
      .PCPlus4D   (PCPlus4D),
      .ValidD     (ValidD),
      .FlushE     (FlushE),
      .StallCount (StallCount),
      .FlushCount (FlushCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      FEN       = 1'b1;
      DEN       = 1'b1;
      PCSrcE    = 1'b0;
      PCTargetE = 32'd0;
      InstrF    = 32'h0000_0000;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; FEN = 1'b1; DEN = 1'b1; PCSrcE = 1'b0;
      PCTargetE = 32'd0; InstrF = 32'h00A0_0093;
      #3;
      checks++;
      if (PCF !== 32'h0 || InstrD !== 32'h13 || PCD !== 32'h0 || PCPlus4D !== 32'h0 || ValidD !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: PCF=%h InstrD=%h PCD=%h PCPlus4D=%h ValidD=%b, want 0/00000013/0/0/0",
                  PCF, InstrD, PCD, PCPlus4D, ValidD);
      end
      checks++;
      if (StallCount !== 4'd0 || FlushCount !== 4'd0 || FlushE !== 1'b0) begin
         errors++;
         $display("FAIL reset_counters: Stall=%0d Flush=%0d FlushE=%b, want 0/0/0", StallCount, FlushCount, FlushE);
      end
   endtask

   task automatic test_sequential_fetch();
      do_reset();
      InstrF = 32'h00A0_0093;
      checks++;
      if (PCF !== 32'h0) begin
         errors++;
         $display("FAIL first_fetch_pc: got %h want 00000000", PCF);
      end
      for (int i = 1; i <= 4; i++) begin
         step();
         checks++;
         if (PCF !== 32'(4 * i) || PCD !== 32'(4 * (i - 1)) || InstrD !== 32'h00A0_0093 || ValidD !== 1'b1) begin
            errors++;
            $display("FAIL seq_fetch_%0d: PCF=%h PCD=%h InstrD=%h ValidD=%b, want %h/%h/00a00093/1",
                     i, PCF, PCD, InstrD, ValidD, 32'(4 * i), 32'(4 * (i - 1)));
         end
      end
      checks++;
      if (PCD !== 32'hC || PCPlus4D !== 32'h10) begin
         errors++;
         $display("FAIL seq_cycle4: PCD=%h PCPlus4D=%h, want 0000000c/00000010", PCD, PCPlus4D);
      end
      // Asynchronous reset mid-run, observed before the next rising edge.
      #2 rst = 1'b1;
      #1;
      checks++;
      if (PCF !== 32'h0 || ValidD !== 1'b0 || InstrD !== 32'h13) begin
         errors++;
         $display("FAIL async_reset: PCF=%h ValidD=%b InstrD=%h, want 0/0/00000013", PCF, ValidD, InstrD);
      end
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_load_use();
      do_reset();
      InstrF = 32'h00A0_0093;
      for (int i = 0; i < 8; i++) step();
      InstrF = 32'h1111_1111;
      FEN = 1'b0; DEN = 1'b0;
      #1;
      checks++;
      if (PCF !== 32'h20 || FlushE !== 1'b1) begin
         errors++;
         $display("FAIL loaduse_flushE: PCF=%h FlushE=%b, want 00000020/1", PCF, FlushE);
      end
      step();
      checks++;
      if (PCF !== 32'h20 || PCD !== 32'h1C || InstrD !== 32'h00A0_0093 || StallCount !== 4'd1) begin
         errors++;
         $display("FAIL loaduse_hold: PCF=%h PCD=%h InstrD=%h Stall=%0d, want 20/1c/00a00093/1",
                  PCF, PCD, InstrD, StallCount);
      end
      FEN = 1'b1; DEN = 1'b1;
      step();
      checks++;
      if (PCF !== 32'h24 || PCD !== 32'h20 || InstrD !== 32'h1111_1111 || StallCount !== 4'd1 || FlushE !== 1'b0) begin
         errors++;
         $display("FAIL loaduse_resume: PCF=%h PCD=%h InstrD=%h Stall=%0d FlushE=%b, want 24/20/11111111/1/0",
                  PCF, PCD, InstrD, StallCount, FlushE);
      end
   endtask

   task automatic test_redirect();
      do_reset();
      InstrF = 32'h00A0_0093;
      for (int i = 0; i < 16; i++) step();
      PCSrcE = 1'b1; PCTargetE = 32'h0000_0103;
      #1;
      checks++;
      if (PCF !== 32'h40 || FlushE !== 1'b1) begin
         errors++;
         $display("FAIL redirect_flushE: PCF=%h FlushE=%b, want 00000040/1", PCF, FlushE);
      end
      step();
      checks++;
      if (PCF !== 32'h100 || InstrD !== 32'h13 || ValidD !== 1'b0 || PCD !== 32'h0 || PCPlus4D !== 32'h0 || FlushCount !== 4'd1) begin
         errors++;
         $display("FAIL redirect: PCF=%h InstrD=%h ValidD=%b PCD=%h PCPlus4D=%h Flush=%0d, want 100/13/0/0/0/1",
                  PCF, InstrD, ValidD, PCD, PCPlus4D, FlushCount);
      end
      PCSrcE = 1'b0;
      step();
      checks++;
      if (PCF !== 32'h104 || PCD !== 32'h100 || ValidD !== 1'b1 || FlushCount !== 4'd1 || StallCount !== 4'd0) begin
         errors++;
         $display("FAIL redirect_after: PCF=%h PCD=%h ValidD=%b Flush=%0d Stall=%0d, want 104/100/1/1/0",
                  PCF, PCD, ValidD, FlushCount, StallCount);
      end
   endtask

   task automatic test_redirect_vs_stall();
      do_reset();
      InstrF = 32'h2222_2222;
      step(); step();
      PCSrcE = 1'b1; PCTargetE = 32'h80; FEN = 1'b0; DEN = 1'b0;
      step();
      checks++;
      if (PCF !== 32'h80 || InstrD !== 32'h13 || ValidD !== 1'b0 || PCD !== 32'h0 || StallCount !== 4'd0 || FlushCount !== 4'd1) begin
         errors++;
         $display("FAIL redirect_wins: PCF=%h InstrD=%h ValidD=%b PCD=%h Stall=%0d Flush=%0d, want 80/13/0/0/0/1",
                  PCF, InstrD, ValidD, PCD, StallCount, FlushCount);
      end
      PCSrcE = 1'b0; FEN = 1'b1; DEN = 1'b1;
   endtask

   task automatic test_wrap();
      do_reset();
      InstrF = 32'h3333_3333;
      PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFF;
      step();
      checks++;
      if (PCF !== 32'hFFFF_FFFC) begin
         errors++;
         $display("FAIL wrap_target_align: got %h want fffffffc", PCF);
      end
      PCSrcE = 1'b0;
      step();
      checks++;
      if (PCF !== 32'h0 || PCD !== 32'hFFFF_FFFC || PCPlus4D !== 32'h0 || ValidD !== 1'b1) begin
         errors++;
         $display("FAIL wrap: PCF=%h PCD=%h PCPlus4D=%h ValidD=%b, want 0/fffffffc/0/1", PCF, PCD, PCPlus4D, ValidD);
      end
   endtask

   task automatic test_fen_without_den();
      do_reset();
      InstrF = 32'h4444_4444;
      step();
      InstrF = 32'h5555_5555; DEN = 1'b0;
      step();
      checks++;
      if (PCF !== 32'h8 || PCD !== 32'h0 || InstrD !== 32'h4444_4444 || FlushE !== 1'b1 || StallCount !== 4'd0) begin
         errors++;
         $display("FAIL den_hold: PCF=%h PCD=%h InstrD=%h FlushE=%b Stall=%0d, want 8/0/44444444/1/0",
                  PCF, PCD, InstrD, FlushE, StallCount);
      end
      DEN = 1'b1;
   endtask

   task automatic test_saturation();
      do_reset();
      FEN = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (i == 14 || i == 15 || i == 20) begin
            checks++;
            if (StallCount !== 4'((i > 15) ? 15 : i)) begin
               errors++;
               $display("FAIL stall_sat_%0d: got %0d want %0d", i, StallCount, (i > 15) ? 15 : i);
            end
         end
      end
      FEN = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h200;
      for (int i = 0; i < 18; i++) step();
      checks++;
      if (FlushCount !== 4'd15 || StallCount !== 4'd15) begin
         errors++;
         $display("FAIL flush_sat: Flush=%0d Stall=%0d, want 15/15", FlushCount, StallCount);
      end
      PCSrcE = 1'b0;
   endtask

   initial begin
      test_reset();
      test_sequential_fetch();
      test_load_use();
      test_redirect();
      test_redirect_vs_stall();
      test_wrap();
      test_fen_without_den();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fetch_decode_stage.md
Name: fetch_decode_stage

Overview:
- Owns the program counter and the IF/ID pipeline register. Sits directly upstream of the execute-stage forwarding/stall logic.
- Consumes the FEN/DEN stall enables and the branch/jump redirect from execute. Produces PCF to instruction memory and the decoded-stage fields InstrD/PCD/PCPlus4D/ValidD.
- Drives FlushE, which clears the ID/EX register and inserts a bubble on a load-use stall or a redirect.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0013, instruction injected into decode on flush/reset (addi x0,x0,0)
- CNT_W, 16, width of stall/flush counters

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- FEN  input  1  fetch enable; 0 = hold PC (load-use stall)
- DEN  input  1  decode enable; 0 = hold IF/ID register
- PCSrcE  input  1  taken branch/jump resolved in execute
- PCTargetE  input  32  redirect target from execute
- InstrF  input  32  instruction read combinationally from imem at PCF
- PCF  output  32  current fetch address
- InstrD  output  32  instruction in decode
- PCD  output  32  PC of InstrD
- PCPlus4D  output  32  PCD+4
- ValidD  output  1  1 = InstrD is a real instruction, 0 = bubble
- FlushE  output  1  clear request for ID/EX register
- StallCount  output  CNT_W  cycles with FEN=0 and PCSrcE=0
- FlushCount  output  CNT_W  cycles with PCSrcE=1

Behaviour:
- Reset (async, rst=1): PCF=RESET_PC, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, StallCount=0, FlushCount=0. Outputs take these values immediately on rst assertion, independent of clk. Reset asserted mid-stall or mid-redirect discards all pending state. The first fetch after deassertion is at RESET_PC.
- PCPlus4F = PCF + 32'd4, computed combinationally, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- PC next-state priority:
  1. PCSrcE=1: PCF <= {PCTargetE[31:2],2'b00}. Low bits are forced to 0, with no trap.
  2. FEN=1: PCF <= PCPlus4F.
  3. Otherwise hold.
- PCSrcE overrides FEN=0. A stall and a redirect are mutually exclusive in normal operation, but the priority must hold if both occur.
- IF/ID register priority:
  1. PCSrcE=1 (flush): InstrD <= NOP_INSTR, PCD <= 0, PCPlus4D <= 0, ValidD <= 0.
  2. DEN=1: InstrD <= InstrF, PCD <= PCF, PCPlus4D <= PCPlus4F, ValidD <= 1.
  3. Otherwise hold all four.
- FlushE = PCSrcE | ~DEN. This is combinational with no register. It clears ID/EX on the cycle the load-use stall is detected and on redirects, two bubbles total per taken branch (IF/ID flushed here, ID/EX via FlushE).
- Latency: an instruction fetched at PCF in cycle N appears on InstrD in cycle N+1 if DEN=1.
- FEN=1 with DEN=0 is illegal upstream. If it occurs, the PC advances and the IF/ID register holds, so the fetched instruction is lost. No assertion is required in RTL.
- StallCount increments when FEN=0 and PCSrcE=0. FlushCount increments when PCSrcE=1. Both saturate at 2^CNT_W-1 and never wrap.
- No combinational path from InstrF to any output except through the IF/ID register.

Test Plan:
- Reset then 4 cycles FEN=DEN=1, InstrF=0x00A00093 -> PCF 0,4,8,C,10; InstrD=0x00A00093, PCD=0xC, PCPlus4D=0x10, ValidD=1 in cycle 4. rst raised mid-run returns PCF=0, ValidD=0 asynchronously, before the next edge.
- Load-use: at PCF=0x20, hold FEN=DEN=0 for one cycle -> PCF stays 0x20, InstrD/PCD unchanged, FlushE=1 that cycle, StallCount increments by 1; next cycle resumes at 0x24.
- Redirect: PCSrcE=1, PCTargetE=0x0000_0103 at PCF=0x40 -> next PCF=0x100, InstrD=0x00000013, ValidD=0, PCD=0, FlushE=1, FlushCount=1.
- Simultaneous PCSrcE=1 with FEN=DEN=0, PCTargetE=0x80 -> PCF=0x80 and IF/ID flushed (redirect wins), StallCount unchanged.
- Wrap: force PC to 0xFFFF_FFFC via redirect, then FEN=1 -> PCF=0x0, PCPlus4D captured as 0x0.
- Saturation with CNT_W=4: hold FEN=0 for 20 cycles -> StallCount stops at 15.
